alu_modport: RTL and testbench
==============================

Name: alu_modport

Overview:
- Parameterised, clocked integer ALU with an arithmetic mode and a logical mode.
- Each operand carries its own valid bit, so operands may arrive in different cycles.
- Produces a registered result plus carry, overflow, compare and error flags.
- Sits behind the ALU interface as the DUT driven by the driver, monitor and reference clocking blocks.

Parameters:
- N, 8, operand width.
- M, 4, command width.
- REQUIRED_BITS, 3, rotate-amount width (log2 N).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- ce  in  1  clock enable; when 0, all state and outputs hold.
- inp_valid  in  2  operand valid: bit0 = opa, bit1 = opb.
- mode  in  1  1 = arithmetic, 0 = logical.
- cmd  in  M  operation select.
- opa  in  N  operand A.
- opb  in  N  operand B.
- cin  in  1  carry-in.
- res  out  N+2  result.
- cout  out  1  carry out.
- oflow  out  1  overflow / borrow.
- g  out  1  A>B.
- l  out  1  A<B.
- e  out  1  A==B.
- err  out  1  error.

Behaviour:
- Reset (reset=0, asynchronous): res, cout, oflow, g, l, e, err all driven to high-Z; internal operand latches, wait counter and pipeline are cleared.
- First enabled edge after release: outputs become driven values; unused flags are 0.
- Timing: inputs are sampled on a posedge with ce=1, and outputs register on that same edge (visible to the next sample).
  - MUL_INC and MUL_SHIFT take one extra cycle.
  - Every new operation clears all flags not set by that operation.
- ce=0: outputs, latches and the wait counter hold unchanged.
- Arithmetic commands (mode=1), all unsigned:
  - 0 ADD: A+B; cout = carry.
  - 1 SUB: A-B; oflow = (A<B).
  - 2 ADD_CIN: A+B+cin; cout = carry.
  - 3 SUB_CIN: A-B-cin; oflow = borrow.
  - 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B.
  - 8 CMP: res=0; set exactly one of g/l/e.
  - 9 MUL_INC: (A+1)*(B+1).
  - 10 MUL_SHIFT: (A<<1)*B.
  - Multiply results are truncated to N+2 bits. Sums are zero-extended into res.
  - cmd>10: err=1, res=0.
- Logical commands (mode=0), res upper bits 0:
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
  - 6 NOT_A, 7 NOT_B.
  - 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B.
  - 12 ROL_A_B: rotate A left by opb[REQUIRED_BITS-1:0].
  - 13 ROR_A_B: rotate A right by the same amount.
  - ROL/ROR: if any of opb[N-1:REQUIRED_BITS+1] is 1, set err=1 and still return the rotated value.
  - cmd>13: err=1, res=0.
- Operand requirements:
  - Single-operand ops need only their operand's valid bit (INC_A/DEC_A/NOT_A/SHx_A need bit0; the _B variants need bit1).
  - All other ops need both operands.
- inp_valid handling:
  - 00: err=1 on that edge; no result update.
  - 01 or 10 on a two-operand op: latch the supplied operand and start a 16-cycle wait counter.
  - If the missing operand arrives (its valid bit set, same cmd/mode) before the counter expires, execute with the latched plus new operand and clear the counter.
  - Otherwise err=1 on the 16th enabled edge after the first partial sample, and the wait is abandoned.
  - 11: execute immediately; this cancels any pending wait.
- Simultaneous events:
  - Reset dominates everything.
  - A cmd/mode change during a wait abandons the wait and starts the new command.
  - Reset in mid-wait or mid-multiply discards the operation.

Test Plan:
- Reset: hold reset=0 → all outputs Z. Release, then ADD opa=8'h10, opb=8'h20, inp_valid=11, ce=1 → res=10'h030, cout=0, err=0 one edge later.
- Carry and borrow:
  - ADD_CIN 8'hFF+8'h01, cin=1 → res=10'h101, cout=1.
  - SUB 8'h05-8'h07 → oflow=1.
  - CMP 8'h33 vs 8'h33 → e=1, g=0, l=0.
- Multiply: MUL_INC with A=3, B=4 → res=20, two edges after sampling. MUL_SHIFT with A=3, B=4 → res=24.
- Rotate: ROL_A_B A=8'h81, opb=8'h01 → res=10'h003, err=0. Same with opb=8'h11 → err=1.
- Split operands and timeout:
  - ADD with inp_valid=01 (A=5), then 10 (B=6) three cycles later → res=11, err=0.
  - inp_valid=01 held for 16 edges with no B → err=1 at the 16th edge.
- Errors and enable:
  - inp_valid=00 → err=1 next cycle.
  - mode=1, cmd=12 → err=1.
  - mode=0, cmd=14 → err=1.
  - ce=0 for 5 cycles with changing inputs → all outputs stable.

Source files
------------

// File: rtl/alu_modport_if.sv
// alu_modport_if: operand/command bundle between a driver and the ALU.
//
// Signals
//   ce         clock enable; when low the ALU holds every register.
//   inp_valid  per-operand valid: bit0 qualifies opa, bit1 qualifies opb.
//   mode       1 = arithmetic, 0 = logical.
//   cmd        operation select (M bits).
//   opa, opb   operands (N bits).
//   cin        carry-in for ADD_CIN / SUB_CIN.
//   dbg_state  ALU control state (0 idle, 1 waiting for an operand, 2 multiply).
//   dbg_drive  1 once the ALU drives its result/flag outputs after reset.
//
// Handshake: there is no ready. An operand is taken on every rising clk edge
// where ce=1 and its inp_valid bit is 1. A two-operand command with only one
// valid bit keeps that operand and waits up to 16 enabled edges for the other
// operand under the same cmd/mode. inp_valid=00 on an enabled edge flags an
// error and changes no result.
//
// Modports
//   master  drives the operation inputs and observes the debug outputs.
//   slave   the ALU itself.
interface alu_modport_if #(
    parameter int N = 8,
    parameter int M = 4
);
    logic         ce;
    logic [1:0]   inp_valid;
    logic         mode;
    logic [M-1:0] cmd;
    logic [N-1:0] opa;
    logic [N-1:0] opb;
    logic         cin;
    logic [1:0]   dbg_state;
    logic         dbg_drive;

    modport master (
        output ce, inp_valid, mode, cmd, opa, opb, cin,
        input  dbg_state, dbg_drive
    );

    modport slave (
        input  ce, inp_valid, mode, cmd, opa, opb, cin,
        output dbg_state, dbg_drive
    );
endinterface

// File: rtl/alu_modport.sv
// alu_modport: clocked unsigned integer ALU with arithmetic and logical modes.
//
// Ports
//   clk    rising-edge clock.
//   reset  asynchronous active-low reset; outputs float (high-Z) while low.
//   bus    alu_modport_if.slave: ce, inp_valid, mode, cmd, opa, opb, cin in;
//          dbg_state / dbg_drive out.
//   res    N+2-bit registered result.
//   cout   carry out (ADD, ADD_CIN).
//   oflow  borrow (SUB, SUB_CIN).
//   g/l/e  A>B / A<B / A==B (CMP only).
//   err    invalid command, missing operands, rotate range error or timeout.
//
// Operands can arrive on different edges: a partial operand is latched and a
// wait counter runs until the partner arrives under the same cmd/mode.
// MUL_INC and MUL_SHIFT spend one extra enabled edge before the result
// registers; inputs presented on that edge are ignored.
module alu_modport #(
    parameter int N             = 8,
    parameter int M             = 4,
    parameter int REQUIRED_BITS = 3
) (
    input  logic          clk,
    input  logic          reset,
    alu_modport_if.slave  bus,
    output wire  [N+1:0]  res,
    output wire           cout,
    output wire           oflow,
    output wire           g,
    output wire           l,
    output wire           e,
    output wire           err
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

    // Arithmetic commands
    localparam logic [M-1:0] A_ADD       = M'(0);
    localparam logic [M-1:0] A_SUB       = M'(1);
    localparam logic [M-1:0] A_ADD_CIN   = M'(2);
    localparam logic [M-1:0] A_SUB_CIN   = M'(3);
    localparam logic [M-1:0] A_INC_A     = M'(4);
    localparam logic [M-1:0] A_DEC_A     = M'(5);
    localparam logic [M-1:0] A_INC_B     = M'(6);
    localparam logic [M-1:0] A_DEC_B     = M'(7);
    localparam logic [M-1:0] A_CMP       = M'(8);
    localparam logic [M-1:0] A_MUL_INC   = M'(9);
    localparam logic [M-1:0] A_MUL_SHIFT = M'(10);
    // Logical commands
    localparam logic [M-1:0] L_AND    = M'(0);
    localparam logic [M-1:0] L_NAND   = M'(1);
    localparam logic [M-1:0] L_OR     = M'(2);
    localparam logic [M-1:0] L_NOR    = M'(3);
    localparam logic [M-1:0] L_XOR    = M'(4);
    localparam logic [M-1:0] L_XNOR   = M'(5);
    localparam logic [M-1:0] L_NOT_A  = M'(6);
    localparam logic [M-1:0] L_NOT_B  = M'(7);
    localparam logic [M-1:0] L_SHR1_A = M'(8);
    localparam logic [M-1:0] L_SHL1_A = M'(9);
    localparam logic [M-1:0] L_SHR1_B = M'(10);
    localparam logic [M-1:0] L_SHL1_B = M'(11);
    localparam logic [M-1:0] L_ROL    = M'(12);
    localparam logic [M-1:0] L_ROR    = M'(13);

    localparam logic [REQUIRED_BITS:0] NW    = (REQUIRED_BITS + 1)'(N);
    localparam logic [N:0]             ONE_S = (N + 1)'(1);
    localparam logic [N-1:0]           ONE_N = N'(1);
    localparam logic [N+1:0]           ONE_W = (N + 2)'(1);

    // Registered state
    state_t       state_q, state_d;
    logic [N-1:0] a_lat_q, a_lat_d, b_lat_q, b_lat_d;
    logic         a_ok_q, a_ok_d, b_ok_q, b_ok_d;
    logic [M-1:0] pcmd_q, pcmd_d;
    logic         pmode_q, pmode_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [N+1:0] mul_q, mul_d;
    logic [N+1:0] res_q, res_d;
    logic         cout_q, cout_d, oflow_q, oflow_d;
    logic         g_q, g_d, l_q, l_d, e_q, e_d, err_q, err_d;
    logic         drive_q, drive_d;

    // Operand selection
    logic         need_a, need_b, same_op, have_a, have_b, ready, is_mul;
    logic [N-1:0] a_use, b_use;

    always_comb begin
        need_a  = 1'b1;
        need_b  = 1'b1;
        if (bus.mode) begin
            if (bus.cmd == A_INC_A || bus.cmd == A_DEC_A) need_b = 1'b0;
            if (bus.cmd == A_INC_B || bus.cmd == A_DEC_B) need_a = 1'b0;
            // Invalid commands report err without waiting for operands.
            if (bus.cmd > A_MUL_SHIFT) begin
                need_a = 1'b0;
                need_b = 1'b0;
            end
        end else begin
            if (bus.cmd == L_NOT_A || bus.cmd == L_SHR1_A || bus.cmd == L_SHL1_A) need_b = 1'b0;
            if (bus.cmd == L_NOT_B || bus.cmd == L_SHR1_B || bus.cmd == L_SHL1_B) need_a = 1'b0;
            if (bus.cmd > L_ROR) begin
                need_a = 1'b0;
                need_b = 1'b0;
            end
        end
        same_op = (state_q == ST_WAIT) && (bus.cmd == pcmd_q) && (bus.mode == pmode_q);
        have_a  = bus.inp_valid[0] | (same_op & a_ok_q);
        have_b  = bus.inp_valid[1] | (same_op & b_ok_q);
        a_use   = bus.inp_valid[0] ? bus.opa : a_lat_q;
        b_use   = bus.inp_valid[1] ? bus.opb : b_lat_q;
        ready   = (!need_a || have_a) && (!need_b || have_b);
        is_mul  = bus.mode && (bus.cmd == A_MUL_INC || bus.cmd == A_MUL_SHIFT);
    end

    // Datapath
    logic [N:0]               sum_ab, sum_cin, diff_ab, diff_cin, inc_a, inc_b;
    logic [N-1:0]             dec_a, dec_b, rol_v, ror_v;
    logic [N+1:0]             mul_inc_v, mul_shift_v;
    logic [REQUIRED_BITS-1:0] rot_amt;
    logic                     rot_err;

    assign sum_ab      = {1'b0, a_use} + {1'b0, b_use};
    assign sum_cin     = sum_ab + {{N{1'b0}}, bus.cin};
    // N+1-bit differences: the top bit is the borrow.
    assign diff_ab     = {1'b0, a_use} - {1'b0, b_use};
    assign diff_cin    = diff_ab - {{N{1'b0}}, bus.cin};
    assign inc_a       = {1'b0, a_use} + ONE_S;
    assign inc_b       = {1'b0, b_use} + ONE_S;
    assign dec_a       = a_use - ONE_N;
    assign dec_b       = b_use - ONE_N;
    assign mul_inc_v   = ({2'b00, a_use} + ONE_W) * ({2'b00, b_use} + ONE_W);
    assign mul_shift_v = {1'b0, a_use, 1'b0} * {2'b00, b_use};
    assign rot_amt     = b_use[REQUIRED_BITS-1:0];
    // Bit REQUIRED_BITS of opb is deliberately not part of the range check.
    assign rot_err     = |b_use[N-1:REQUIRED_BITS+1];
    assign rol_v       = (a_use << rot_amt) | (a_use >> (NW - {1'b0, rot_amt}));
    assign ror_v       = (a_use >> rot_amt) | (a_use << (NW - {1'b0, rot_amt}));

    logic [N+1:0] alu_res;
    logic         alu_cout, alu_oflow, alu_g, alu_l, alu_e, alu_err;

    always_comb begin
        alu_res   = '0;
        alu_cout  = 1'b0;
        alu_oflow = 1'b0;
        alu_g     = 1'b0;
        alu_l     = 1'b0;
        alu_e     = 1'b0;
        alu_err   = 1'b0;
        if (bus.mode) begin
            case (bus.cmd)
                A_ADD:       begin alu_res = {1'b0, sum_ab};  alu_cout = sum_ab[N]; end
                A_SUB:       begin alu_res = {2'b00, diff_ab[N-1:0]};  alu_oflow = diff_ab[N]; end
                A_ADD_CIN:   begin alu_res = {1'b0, sum_cin}; alu_cout = sum_cin[N]; end
                A_SUB_CIN:   begin alu_res = {2'b00, diff_cin[N-1:0]}; alu_oflow = diff_cin[N]; end
                A_INC_A:     alu_res = {1'b0, inc_a};
                A_DEC_A:     alu_res = {2'b00, dec_a};
                A_INC_B:     alu_res = {1'b0, inc_b};
                A_DEC_B:     alu_res = {2'b00, dec_b};
                A_CMP: begin
                    alu_g = (a_use > b_use);
                    alu_l = (a_use < b_use);
                    alu_e = (a_use == b_use);
                end
                A_MUL_INC:   alu_res = mul_inc_v;
                A_MUL_SHIFT: alu_res = mul_shift_v;
                default:     alu_err = 1'b1;
            endcase
        end else begin
            case (bus.cmd)
                L_AND:    alu_res = {2'b00, a_use & b_use};
                L_NAND:   alu_res = {2'b00, ~(a_use & b_use)};
                L_OR:     alu_res = {2'b00, a_use | b_use};
                L_NOR:    alu_res = {2'b00, ~(a_use | b_use)};
                L_XOR:    alu_res = {2'b00, a_use ^ b_use};
                L_XNOR:   alu_res = {2'b00, ~(a_use ^ b_use)};
                L_NOT_A:  alu_res = {2'b00, ~a_use};
                L_NOT_B:  alu_res = {2'b00, ~b_use};
                L_SHR1_A: alu_res = {2'b00, a_use >> 1};
                L_SHL1_A: alu_res = {2'b00, a_use << 1};
                L_SHR1_B: alu_res = {2'b00, b_use >> 1};
                L_SHL1_B: alu_res = {2'b00, b_use << 1};
                L_ROL:    begin alu_res = {2'b00, rol_v}; alu_err = rot_err; end
                L_ROR:    begin alu_res = {2'b00, ror_v}; alu_err = rot_err; end
                default:  alu_err = 1'b1;
            endcase
        end
    end

    // Control: next-state and register updates
    always_comb begin
        state_d = state_q;
        a_lat_d = a_lat_q;
        b_lat_d = b_lat_q;
        a_ok_d  = a_ok_q;
        b_ok_d  = b_ok_q;
        pcmd_d  = pcmd_q;
        pmode_d = pmode_q;
        cnt_d   = cnt_q;
        mul_d   = mul_q;
        res_d   = res_q;
        cout_d  = cout_q;
        oflow_d = oflow_q;
        g_d     = g_q;
        l_d     = l_q;
        e_d     = e_q;
        err_d   = err_q;
        drive_d = drive_q;
        if (bus.ce) begin
            drive_d = 1'b1;
            if (state_q == ST_MUL) begin
                // Second multiply edge: publish the product, clear every flag.
                state_d = ST_IDLE;
                res_d   = mul_q;
                cout_d  = 1'b0;
                oflow_d = 1'b0;
                g_d     = 1'b0;
                l_d     = 1'b0;
                e_d     = 1'b0;
                err_d   = 1'b0;
            end else if (bus.inp_valid == 2'b00) begin
                // No operands: flag it, keep the result; a pending wait keeps ageing.
                err_d = 1'b1;
                if (state_q == ST_WAIT) begin
                    if (cnt_q == 4'd15) begin
                        state_d = ST_IDLE;
                        a_ok_d  = 1'b0;
                        b_ok_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end else if (ready) begin
                a_ok_d = 1'b0;
                b_ok_d = 1'b0;
                cnt_d  = 4'd0;
                if (is_mul) begin
                    state_d = ST_MUL;
                    mul_d   = alu_res;
                end else begin
                    state_d = ST_IDLE;
                    res_d   = alu_res;
                    cout_d  = alu_cout;
                    oflow_d = alu_oflow;
                    g_d     = alu_g;
                    l_d     = alu_l;
                    e_d     = alu_e;
                    err_d   = alu_err;
                end
            end else if (same_op) begin
                // Still missing the partner operand: refresh and age the wait.
                if (bus.inp_valid[0]) begin a_lat_d = bus.opa; a_ok_d = 1'b1; end
                if (bus.inp_valid[1]) begin b_lat_d = bus.opb; b_ok_d = 1'b1; end
                if (cnt_q == 4'd15) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    a_ok_d  = 1'b0;
                    b_ok_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                // First partial sample of a new command (abandons any old wait).
                state_d = ST_WAIT;
                pcmd_d  = bus.cmd;
                pmode_d = bus.mode;
                cnt_d   = 4'd0;
                a_ok_d  = bus.inp_valid[0];
                b_ok_d  = bus.inp_valid[1];
                if (bus.inp_valid[0]) a_lat_d = bus.opa;
                if (bus.inp_valid[1]) b_lat_d = bus.opb;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            a_lat_q <= '0;
            b_lat_q <= '0;
            a_ok_q  <= 1'b0;
            b_ok_q  <= 1'b0;
            pcmd_q  <= '0;
            pmode_q <= 1'b0;
            cnt_q   <= '0;
            mul_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            oflow_q <= 1'b0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
            err_q   <= 1'b0;
            drive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_lat_q <= a_lat_d;
            b_lat_q <= b_lat_d;
            a_ok_q  <= a_ok_d;
            b_ok_q  <= b_ok_d;
            pcmd_q  <= pcmd_d;
            pmode_q <= pmode_d;
            cnt_q   <= cnt_d;
            mul_q   <= mul_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            oflow_q <= oflow_d;
            g_q     <= g_d;
            l_q     <= l_d;
            e_q     <= e_d;
            err_q   <= err_d;
            drive_q <= drive_d;
        end
    end

    // Outputs float from reset until the first enabled edge.
    assign res   = drive_q ? res_q   : {(N + 2){1'bz}};
    assign cout  = drive_q ? cout_q  : 1'bz;
    assign oflow = drive_q ? oflow_q : 1'bz;
    assign g     = drive_q ? g_q     : 1'bz;
    assign l     = drive_q ? l_q     : 1'bz;
    assign e     = drive_q ? e_q     : 1'bz;
    assign err   = drive_q ? err_q   : 1'bz;

    assign bus.dbg_state = state_q;
    assign bus.dbg_drive = drive_q;
endmodule

// File: tb/tb_alu_modport.sv
module tb_alu_modport;
    localparam int N  = 8;
    localparam int M  = 4;
    localparam int RB = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;

    logic         clk;
    logic         reset;
    wire  [N+1:0] res;
    wire          cout, oflow, g, l, e, err;

    int checks = 0;
    int errors = 0;

    alu_modport_if #(.N(N), .M(M)) bus ();

    alu_modport #(.N(N), .M(M), .REQUIRED_BITS(RB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .res   (res),
        .cout  (cout),
        .oflow (oflow),
        .g     (g),
        .l     (l),
        .e     (e),
        .err   (err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one operation, let one edge take it, then settle past the edge.
    task automatic apply(input logic m, input logic [3:0] c, input logic [7:0] a,
                         input logic [7:0] b, input logic [1:0] v, input logic ci);
        bus.mode      = m;
        bus.cmd       = c;
        bus.opa       = a;
        bus.opb       = b;
        bus.inp_valid = v;
        bus.cin       = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b0;
        bus.ce        = 1'b1;
        bus.mode      = 1'b0;
        bus.cmd       = '0;
        bus.opa       = '0;
        bus.opb       = '0;
        bus.inp_valid = 2'b00;
        bus.cin       = 1'b0;

        // Reset: outputs undriven, control idle
        repeat (3) tick();
        check("rst_drive", 32'(bus.dbg_drive), 32'h0);
        check("rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
        reset = 1'b1;
        #1;
        check("rel_no_edge_drive", 32'(bus.dbg_drive), 32'h0);

        // First enabled edge after release
        apply(1'b1, 4'd0, 8'h10, 8'h20, 2'b11, 1'b0);
        check("add_res", 32'(res), 32'h030);
        check("add_cout", 32'(cout), 32'h0);
        check("add_err", 32'(err), 32'h0);
        check("add_oflow", 32'(oflow), 32'h0);
        check("add_drive", 32'(bus.dbg_drive), 32'h1);

        // Carry / borrow / compare
        apply(1'b1, 4'd2, 8'hFF, 8'h01, 2'b11, 1'b1);
        check("addcin_res", 32'(res), 32'h101);
        check("addcin_cout", 32'(cout), 32'h1);
        apply(1'b1, 4'd1, 8'h05, 8'h07, 2'b11, 1'b0);
        check("sub_oflow", 32'(oflow), 32'h1);
        check("sub_cout_clr", 32'(cout), 32'h0);
        apply(1'b1, 4'd3, 8'h10, 8'h05, 2'b11, 1'b1);
        check("subcin_res", 32'(res), 32'h00A);
        check("subcin_oflow", 32'(oflow), 32'h0);
        apply(1'b1, 4'd8, 8'h33, 8'h33, 2'b11, 1'b0);
        check("cmp_eq_gle", 32'({g, l, e}), 32'b001);
        check("cmp_eq_res", 32'(res), 32'h000);
        apply(1'b1, 4'd8, 8'h40, 8'h20, 2'b11, 1'b0);
        check("cmp_gt_gle", 32'({g, l, e}), 32'b100);

        // Multiply: result two edges after sampling
        apply(1'b1, 4'd9, 8'h03, 8'h04, 2'b11, 1'b0);
        check("mulinc_busy", 32'(bus.dbg_state), 32'(S_MUL));
        check("mulinc_hold", 32'(res), 32'h000);
        tick();
        check("mulinc_res", 32'(res), 32'h014);
        check("mulinc_flags", 32'({g, l, e}), 32'b000);
        apply(1'b1, 4'd10, 8'h03, 8'h04, 2'b11, 1'b0);
        tick();
        check("mulshift_res", 32'(res), 32'h018);
        apply(1'b1, 4'd9, 8'h20, 8'h20, 2'b11, 1'b0);
        tick();
        check("mulinc_trunc", 32'(res), 32'h041);

        // Rotates
        apply(1'b0, 4'd12, 8'h81, 8'h01, 2'b11, 1'b0);
        check("rol_res", 32'(res), 32'h003);
        check("rol_err", 32'(err), 32'h0);
        apply(1'b0, 4'd12, 8'h81, 8'h11, 2'b11, 1'b0);
        check("rol_range_res", 32'(res), 32'h003);
        check("rol_range_err", 32'(err), 32'h1);
        apply(1'b0, 4'd13, 8'h81, 8'h01, 2'b11, 1'b0);
        check("ror_res", 32'(res), 32'h0C0);
        check("ror_err_clr", 32'(err), 32'h0);
        apply(1'b0, 4'd12, 8'h81, 8'h08, 2'b11, 1'b0);
        check("rol_bit3_res", 32'(res), 32'h081);
        check("rol_bit3_err", 32'(err), 32'h0);

        // Logic ops and single-operand commands
        apply(1'b0, 4'd4, 8'hAA, 8'h0F, 2'b11, 1'b0);
        check("xor_res", 32'(res), 32'h0A5);
        apply(1'b0, 4'd1, 8'hF0, 8'h3C, 2'b11, 1'b0);
        check("nand_res", 32'(res), 32'h0CF);
        apply(1'b0, 4'd9, 8'h81, 8'h00, 2'b01, 1'b0);
        check("shl1a_res", 32'(res), 32'h002);
        apply(1'b0, 4'd7, 8'h00, 8'h0F, 2'b10, 1'b0);
        check("notb_res", 32'(res), 32'h0F0);
        apply(1'b1, 4'd4, 8'hFF, 8'h00, 2'b01, 1'b0);
        check("inca_res", 32'(res), 32'h100);

        // Split operands: A now, B three edges later
        apply(1'b1, 4'd0, 8'h05, 8'h77, 2'b01, 1'b0);
        check("split_wait", 32'(bus.dbg_state), 32'(S_WAIT));
        apply(1'b1, 4'd0, 8'h05, 8'h77, 2'b01, 1'b0);
        apply(1'b1, 4'd0, 8'h05, 8'h77, 2'b01, 1'b0);
        apply(1'b1, 4'd0, 8'hEE, 8'h06, 2'b10, 1'b0);
        check("split_res", 32'(res), 32'h00B);
        check("split_err", 32'(err), 32'h0);
        check("split_idle", 32'(bus.dbg_state), 32'(S_IDLE));

        // Timeout: err on the 16th enabled edge after the first partial sample
        apply(1'b1, 4'd0, 8'h01, 8'h00, 2'b01, 1'b0);
        for (int k = 1; k <= 15; k++) apply(1'b1, 4'd0, 8'h01, 8'h00, 2'b01, 1'b0);
        check("tmo_15_err", 32'(err), 32'h0);
        check("tmo_15_state", 32'(bus.dbg_state), 32'(S_WAIT));
        apply(1'b1, 4'd0, 8'h01, 8'h00, 2'b01, 1'b0);
        check("tmo_16_err", 32'(err), 32'h1);
        check("tmo_16_state", 32'(bus.dbg_state), 32'(S_IDLE));
        check("tmo_res_hold", 32'(res), 32'h00B);

        // No operands, invalid commands
        apply(1'b1, 4'd0, 8'h01, 8'h01, 2'b11, 1'b0);
        check("pre00_res", 32'(res), 32'h002);
        apply(1'b1, 4'd0, 8'h09, 8'h09, 2'b00, 1'b0);
        check("iv00_err", 32'(err), 32'h1);
        check("iv00_res_hold", 32'(res), 32'h002);
        apply(1'b1, 4'd12, 8'h12, 8'h34, 2'b11, 1'b0);
        check("arith_bad_err", 32'(err), 32'h1);
        check("arith_bad_res", 32'(res), 32'h000);
        apply(1'b0, 4'd14, 8'h12, 8'h34, 2'b11, 1'b0);
        check("logic_bad_err", 32'(err), 32'h1);
        check("logic_bad_res", 32'(res), 32'h000);

        // Clock enable low: everything holds despite changing inputs
        apply(1'b1, 4'd0, 8'h10, 8'h20, 2'b11, 1'b0);
        check("pre_ce_res", 32'(res), 32'h030);
        bus.ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apply(i[0], 4'(i + 1), 8'(i * 37 + 3), 8'(i * 91 + 5), 2'(i), i[1]);
            check("ce0_res", 32'(res), 32'h030);
            check("ce0_flags", 32'({cout, oflow, g, l, e, err}), 32'h0);
            check("ce0_state", 32'(bus.dbg_state), 32'(S_IDLE));
        end
        bus.ce = 1'b1;
        apply(1'b1, 4'd2, 8'h01, 8'h01, 2'b11, 1'b1);
        check("ce1_resume", 32'(res), 32'h003);

        // Reset mid-wait discards the latched operand
        apply(1'b1, 4'd0, 8'h05, 8'h00, 2'b01, 1'b0);
        check("rw_wait", 32'(bus.dbg_state), 32'(S_WAIT));
        reset = 1'b0;
        #1;
        check("rw_drive", 32'(bus.dbg_drive), 32'h0);
        check("rw_state", 32'(bus.dbg_state), 32'(S_IDLE));
        reset = 1'b1;
        apply(1'b1, 4'd0, 8'h00, 8'h07, 2'b10, 1'b0);
        check("rw_new_wait", 32'(bus.dbg_state), 32'(S_WAIT));
        check("rw_res_cleared", 32'(res), 32'h000);
        apply(1'b1, 4'd0, 8'h03, 8'h07, 2'b11, 1'b0);
        check("rw_after_res", 32'(res), 32'h00A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
